cache_sim: RTL and testbench
============================

Name: cache_sim

Overview:
- Cycle-driven set-associative cache model that consumes one memory reference per clock and keeps hit/miss/eviction/writeback statistics.
- Used as a trace-driven cache evaluator: the bench applies a read/write flag and an address each cycle and reads the statistics registers hierarchically.
- Write-back, write-allocate, true-LRU replacement. It stores tags and state only; there is no data array.

Parameters:
- SETS, 16, number of sets; power of 2, at least 2.
- ASSOC, 2, ways per set; at least 1.
- LINESIZE, 16, line size in bytes; power of 2, at least 2.
- ADDRESS_SIZE, 16, address width in bits.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- rw  input  1  access type: 0 = read, 1 = write.
- address  input  ADDRESS_SIZE  byte address of the access.

Behaviour:
- Derived constants, exposed as localparams with these names: bsWidth = log2(LINESIZE); indexWidth = log2(SETS); tagWidth = ADDRESS_SIZE - bsWidth - indexWidth. Defaults give 4 / 4 / 8.
- Address fields: offset = address[bsWidth-1:0]; cache_index = address[bsWidth+indexWidth-1:bsWidth]; cache_tag = address[ADDRESS_SIZE-1:bsWidth+indexWidth]. cache_index and cache_tag are combinational internal signals.
- Per line state: valid, dirty, tag[tagWidth], plus an LRU rank of log2(ASSOC) bits (minimum 1 bit). Rank 0 = most recently used; rank ASSOC-1 = LRU.
- Reset (reset==0 at a rising edge): clear all valid and dirty bits, set the LRU ranks in each set to way index, and zero all counters. No access is counted while reset is held.
- Access processing: every rising edge with reset==1 performs exactly one access using rw/address sampled at that edge. All state and counter updates are visible one time unit after the edge. There is no handshake and there are no stalls.
- Hit: a valid way with matching tag exists. Increment cHits. If rw=1, set dirty.
- Miss: increment cMisses. Victim = lowest-numbered invalid way if any, else the way with rank ASSOC-1.
  - If the victim is valid: increment numEvictions; additionally increment numWritebacks if it is dirty.
  - Fill the victim: valid=1, tag=cache_tag, dirty=rw.
- LRU update on every access, hit or fill: the accessed way gets rank 0; ways whose rank was lower than its old rank increment by 1; other ways are unchanged.
- Counters (32-bit, internal, names fixed for hierarchical observation):
  - cAccesses increments on every access.
  - cReads increments when rw=0; cWrites increments when rw=1.
  - cHits, cMisses, numEvictions, numWritebacks as above.
  - Invariants: cAccesses = cReads + cWrites = cHits + cMisses; numWritebacks <= numEvictions.
  - All counters saturate at 2^32-1.
- hitRatio / missRatio: combinational 32-bit values in hundredths of a percent, computed as cHits*10000/cAccesses and cMisses*10000/cAccesses. Both are 0 when cAccesses=0.
- Offset bits never affect hit/miss.
- Reset asserted mid-trace discards all cache contents and statistics at that edge.
- Unknown rw (X) is treated as read.

Test Plan:
- Reset, then read 0x1234 -> miss; cAccesses=1, cReads=1, cMisses=1, cHits=0; cache_index=3, cache_tag=0x12.
- Then read 0x123C -> hit (same line, different offset); cHits=1, hitRatio=5000, missRatio=5000.
- Sequence W 0x1030, R 0x2030, R 0x1030, R 0x3030 -> hits=1, misses=3. The 0x3030 miss evicts clean tag 0x20: numEvictions=1, numWritebacks=0.
- Continue with R 0x4030 -> evicts dirty tag 0x10 (LRU): numEvictions=2, numWritebacks=1. cWrites=1 and cReads=4 for this sequence.
- Fill set 5 with two distinct tags, then access a third tag mapping to set 6 -> no eviction; sets are independent.
- Mid-trace reset low for one cycle, then read a previously cached address -> miss; all counters restart from 0; nothing is counted during the reset cycle.

Source files
------------

// File: rtl/cache_sim.sv
// Trace-driven set-associative cache evaluator: tags and state only, write-back,
// write-allocate, true-LRU. One reference per clock; statistics kept internally.

// Per-way tag compare and LRU detect for the currently indexed set
module cache_way_match #(
  parameter int TW = 8,
  parameter int RW = 1,
  parameter logic [RW-1:0] LRU_RANK = '0
) (
  input  logic          valid,
  input  logic [TW-1:0] tag,
  input  logic [TW-1:0] cache_tag,
  input  logic [RW-1:0] rank,
  output logic          hit,
  output logic          lru
);
  assign hit = valid && (tag == cache_tag);
  assign lru = (rank == LRU_RANK);
endmodule

module cache_sim #(
  parameter int SETS         = 16,
  parameter int ASSOC        = 2,
  parameter int LINESIZE     = 16,
  parameter int ADDRESS_SIZE = 16
) (
  input logic                    clk,
  input logic                    reset,
  input logic                    rw,
  input logic [ADDRESS_SIZE-1:0] address
);
  localparam int bsWidth    = $clog2(LINESIZE);
  localparam int indexWidth = $clog2(SETS);
  localparam int tagWidth   = ADDRESS_SIZE - bsWidth - indexWidth;
  localparam int rankWidth  = (ASSOC > 1) ? $clog2(ASSOC) : 1;

  // line state
  logic [SETS-1:0][ASSOC-1:0]                valid, dirty;
  logic [SETS-1:0][ASSOC-1:0][tagWidth-1:0]  tags;
  logic [SETS-1:0][ASSOC-1:0][rankWidth-1:0] rank;

  // statistics
  logic [31:0] cAccesses, cReads, cWrites, cHits, cMisses, numEvictions, numWritebacks;
  logic [31:0] hitRatio, missRatio;

  logic [indexWidth-1:0] cache_index;
  logic [tagWidth-1:0]   cache_tag;
  logic                  unused_offset;

  assign cache_index   = address[bsWidth+indexWidth-1:bsWidth];
  assign cache_tag     = address[ADDRESS_SIZE-1:bsWidth+indexWidth];
  // offset never takes part in lookup
  assign unused_offset = ^address[bsWidth-1:0];

  logic [ASSOC-1:0]                set_valid, set_dirty, way_hit, way_lru;
  logic [ASSOC-1:0][rankWidth-1:0] set_rank;

  assign set_valid = valid[cache_index];
  assign set_dirty = dirty[cache_index];
  assign set_rank  = rank[cache_index];

  for (genvar w = 0; w < ASSOC; w++) begin : g_way
    cache_way_match #(
      .TW(tagWidth), .RW(rankWidth), .LRU_RANK(rankWidth'(ASSOC-1))
    ) u_match (
      .valid(valid[cache_index][w]),
      .tag(tags[cache_index][w]),
      .cache_tag(cache_tag),
      .rank(rank[cache_index][w]),
      .hit(way_hit[w]),
      .lru(way_lru[w])
    );
  end

  logic                 wr, hit_any, inv_any;
  logic [rankWidth-1:0] hit_way, inv_way, lru_way, acc_way, old_rank;

  // Pick the accessed way: hit way, else lowest invalid way, else LRU way.
  // An X on rw falls into the read branch.
  always_comb begin
    wr      = 1'b0;
    if (rw) wr = 1'b1;
    hit_any = 1'b0;
    inv_any = 1'b0;
    hit_way = '0;
    inv_way = '0;
    lru_way = '0;
    // descending scan so the lowest-numbered match wins
    for (int w = ASSOC-1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit_any = 1'b1;
        hit_way = rankWidth'(w);
      end
      if (!set_valid[w]) begin
        inv_any = 1'b1;
        inv_way = rankWidth'(w);
      end
      if (way_lru[w]) lru_way = rankWidth'(w);
    end
    acc_way  = hit_any ? hit_way : (inv_any ? inv_way : lru_way);
    old_rank = set_rank[acc_way];
  end

  // Line state: fill/dirty on access, move accessed way to rank 0
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
      dirty <= '0;
      tags  <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < ASSOC; w++)
          rank[s][w] <= rankWidth'(w);
    end else begin
      if (hit_any) begin
        if (wr) dirty[cache_index][acc_way] <= 1'b1;
      end else begin
        valid[cache_index][acc_way] <= 1'b1;
        tags[cache_index][acc_way]  <= cache_tag;
        dirty[cache_index][acc_way] <= wr;
      end
      for (int w = 0; w < ASSOC; w++) begin
        if (rankWidth'(w) == acc_way)
          rank[cache_index][w] <= '0;
        else if (set_rank[w] < old_rank)
          rank[cache_index][w] <= set_rank[w] + rankWidth'(1);
      end
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      cAccesses     <= '0;
      cReads        <= '0;
      cWrites       <= '0;
      cHits         <= '0;
      cMisses       <= '0;
      numEvictions  <= '0;
      numWritebacks <= '0;
    end else begin
      cAccesses <= sat_inc(cAccesses);
      if (wr) cWrites <= sat_inc(cWrites);
      else    cReads  <= sat_inc(cReads);
      if (hit_any) begin
        cHits <= sat_inc(cHits);
      end else begin
        cMisses <= sat_inc(cMisses);
        if (set_valid[acc_way]) begin
          numEvictions <= sat_inc(numEvictions);
          if (set_dirty[acc_way]) numWritebacks <= sat_inc(numWritebacks);
        end
      end
    end
  end

  logic [63:0] hit_scaled, miss_scaled;

  // Ratios in hundredths of a percent; wide product avoids overflow
  always_comb begin
    hit_scaled  = 64'(cHits) * 64'd10000;
    miss_scaled = 64'(cMisses) * 64'd10000;
    hitRatio    = '0;
    missRatio   = '0;
    if (cAccesses != '0) begin
      hitRatio  = 32'(hit_scaled / 64'(cAccesses));
      missRatio = 32'(miss_scaled / 64'(cAccesses));
    end
  end
endmodule

// File: tb/tb_cache_sim.sv
// Bench for cache_sim: fixed vector table, corner sequences, randomized trace
// compared against a timestamp-based LRU reference model.
module tb_cache_sim;
  localparam int S = 16;
  localparam int A = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] address = '0;

  always #5 clk = ~clk;

  cache_sim #(.SETS(S), .ASSOC(A), .LINESIZE(16), .ADDRESS_SIZE(16)) dut (
    .clk(clk), .reset(reset), .rw(rw), .address(address)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: each set holds up to A lines stamped with last-use time
  bit          mv[S][A];
  bit          md[S][A];
  logic [7:0]  mt[S][A];
  int unsigned mts[S][A];
  int unsigned now_t;
  longint      m_acc, m_wr, m_rd, m_hit, m_miss, m_ev, m_wb;

  task automatic model(input bit rst, input logic w, input logic [15:0] a);
    int s, k;
    logic [7:0] t;
    bit isw, found;
    if (rst) begin
      for (int i = 0; i < S; i++)
        for (int j = 0; j < A; j++) begin
          mv[i][j] = 0; md[i][j] = 0; mts[i][j] = 0;
        end
      m_acc = 0; m_wr = 0; m_rd = 0; m_hit = 0; m_miss = 0; m_ev = 0; m_wb = 0;
      return;
    end
    isw = (w === 1'b1);
    s = int'(a[7:4]);
    t = a[15:8];
    m_acc++;
    if (isw) m_wr++; else m_rd++;
    found = 0;
    k = 0;
    for (int j = 0; j < A; j++)
      if (mv[s][j] && mt[s][j] == t) begin found = 1; k = j; end
    if (found) begin
      m_hit++;
      if (isw) md[s][k] = 1;
    end else begin
      m_miss++;
      k = -1;
      for (int j = 0; j < A; j++)
        if (!mv[s][j] && k < 0) k = j;
      if (k < 0) begin
        k = 0;
        for (int j = 1; j < A; j++)
          if (mts[s][j] < mts[s][k]) k = j;
        m_ev++;
        if (md[s][k]) m_wb++;
      end
      mv[s][k] = 1;
      mt[s][k] = t;
      md[s][k] = isw;
    end
    now_t++;
    mts[s][k] = now_t;
  endtask

  // one clock: drive, update model, let the edge land, settle
  task automatic step(input bit rst, input logic w, input logic [15:0] a);
    reset   = rst ? 1'b0 : 1'b1;
    rw      = w;
    address = a;
    model(rst, w, a);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic longint ratio(input longint n, input longint d);
    return (d == 0) ? 0 : (n * 10000) / d;
  endfunction

  task automatic check_model(input string ctx);
    chk({ctx, ".acc"},  dut.cAccesses,     m_acc);
    chk({ctx, ".rd"},   dut.cReads,        m_rd);
    chk({ctx, ".wr"},   dut.cWrites,       m_wr);
    chk({ctx, ".hit"},  dut.cHits,         m_hit);
    chk({ctx, ".miss"}, dut.cMisses,       m_miss);
    chk({ctx, ".ev"},   dut.numEvictions,  m_ev);
    chk({ctx, ".wb"},   dut.numWritebacks, m_wb);
    chk({ctx, ".hr"},   dut.hitRatio,      ratio(m_hit, m_acc));
    chk({ctx, ".mr"},   dut.missRatio,     ratio(m_miss, m_acc));
  endtask

  typedef struct {
    bit          rst;
    bit          w;
    logic [15:0] a;
    int          acc, wr, hit, miss, ev, wb;
  } vec_t;

  vec_t tbl[$];

  initial begin
    string nm;
    // cumulative expected counters after each row
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 16'h1234, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 16'h123C, 2, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 16'h1030, 1, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 16'h2030, 2, 1, 0, 2, 0, 0});
    tbl.push_back('{0, 0, 16'h1030, 3, 1, 1, 2, 0, 0});
    tbl.push_back('{0, 0, 16'h3030, 4, 1, 1, 3, 1, 0});
    tbl.push_back('{0, 0, 16'h4030, 5, 1, 1, 4, 2, 1});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 16'h1050, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 16'h2050, 2, 0, 0, 2, 0, 0});
    tbl.push_back('{0, 0, 16'h3060, 3, 0, 0, 3, 0, 0});
    tbl.push_back('{0, 0, 16'h1050, 4, 0, 1, 3, 0, 0});
    tbl.push_back('{0, 0, 16'h2050, 5, 0, 2, 3, 0, 0});
    tbl.push_back('{1, 1, 16'h1050, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 16'h1050, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 16'h1050, 2, 1, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 16'h2050, 3, 1, 1, 2, 0, 0});
    tbl.push_back('{0, 0, 16'h3050, 4, 1, 1, 3, 1, 1});

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].w, tbl[i].a);
      nm = $sformatf("row%0d", i);
      chk({nm, ".acc"},  dut.cAccesses,     tbl[i].acc);
      chk({nm, ".wr"},   dut.cWrites,       tbl[i].wr);
      chk({nm, ".rd"},   dut.cReads,        tbl[i].acc - tbl[i].wr);
      chk({nm, ".hit"},  dut.cHits,         tbl[i].hit);
      chk({nm, ".miss"}, dut.cMisses,       tbl[i].miss);
      chk({nm, ".ev"},   dut.numEvictions,  tbl[i].ev);
      chk({nm, ".wb"},   dut.numWritebacks, tbl[i].wb);
      chk({nm, ".hr"},   dut.hitRatio,      ratio(tbl[i].hit, tbl[i].acc));
      chk({nm, ".mr"},   dut.missRatio,     ratio(tbl[i].miss, tbl[i].acc));
    end

    // address decode and empty-ratio corner
    step(1, 0, 16'h0000);
    address = 16'h1234;
    #1;
    chk("decode.index", dut.cache_index, 3);
    chk("decode.tag",   dut.cache_tag,   8'h12);
    chk("empty.hr",     dut.hitRatio,    0);
    chk("empty.mr",     dut.missRatio,   0);

    // reset held several cycles counts nothing
    step(1, 1, 16'h1234);
    step(1, 0, 16'h1234);
    step(1, 1, 16'h5678);
    check_model("rsthold");

    // unknown rw behaves as a read
    step(0, 1'bx, 16'h0040);
    chk("xrw.rd", dut.cReads, 1);
    chk("xrw.wr", dut.cWrites, 0);
    step(0, 1'b0, 16'h0044);
    chk("xrw.hit", dut.cHits, 1);
    check_model("xrw");

    // randomized trace with a small tag pool to get hits and evictions
    step(1, 0, 16'h0000);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      a = {8'($urandom_range(0, 4)), 4'($urandom), 4'($urandom)};
      step($urandom_range(0, 299) == 0, 1'($urandom), a);
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
